// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op encoding and decode helpers for the pipelined divider
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  function automatic logic is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/divider_stage.sv
// rtl/divider_stage.sv - combinational restoring-division step, BITS_PER_STAGE quotient bits MSB first
module divider_stage #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_STAGE = 2
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] dq_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] dq_out
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // dq holds the unconsumed dividend bits at the top and the quotient growing in from the bottom
  always_comb begin
    rem_out = rem_in;
    dq_out  = dq_in;
    trial   = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      trial   = {rem_out, dq_out[XLEN-1]};
      diff    = trial - {1'b0, divisor};
      dq_out  = {dq_out[XLEN-2:0], ~diff[XLEN]};
      rem_out = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

endmodule

// File: rtl/divider_pipe.sv
// rtl/divider_pipe.sv - fully pipelined signed/unsigned divider with stall and flush
module divider_pipe
  import div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_W          = 8,
  parameter int PC_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  output logic [XLEN-1:0]  Result,
  output logic             div_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic [PC_W-1:0]  out_pc
);

  localparam int N = XLEN / BITS_PER_STAGE;

  logic             valid_q  [0:N];
  div_op_e          op_q     [0:N];
  logic [TAG_W-1:0] tag_q    [0:N];
  logic [PC_W-1:0]  pc_q     [0:N];
  logic             sign_q_q [0:N];
  logic             sign_r_q [0:N];
  logic             zero_q   [0:N];
  logic [XLEN-1:0]  rem_q    [0:N];
  logic [XLEN-1:0]  dq_q     [0:N];
  logic [XLEN-1:0]  dvs_q    [0:N-1];

  logic [XLEN-1:0]  rem_nx   [1:N];
  logic [XLEN-1:0]  dq_nx    [1:N];

  div_op_e          in_op_e;
  logic             in_signed;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;

  logic [XLEN-1:0]  quo_fin;
  logic [XLEN-1:0]  rem_fin;
  logic [XLEN-1:0]  res_fin;

  assign in_ready  = !stall;
  assign in_op_e   = div_op_e'(in_op);
  assign in_signed = is_signed(in_op_e);

  // Unsigned XLEN-bit magnitudes: negating MIN wraps back to 2^(XLEN-1), which is what we want
  assign a_mag = (in_signed && A[XLEN-1]) ? -A : A;
  assign b_mag = (in_signed && B[XLEN-1]) ? -B : B;

  for (genvar k = 1; k <= N; k++) begin : g_stage
    divider_stage #(
      .XLEN           (XLEN),
      .BITS_PER_STAGE (BITS_PER_STAGE)
    ) u_stage (
      .rem_in  (rem_q[k-1]),
      .dq_in   (dq_q[k-1]),
      .divisor (dvs_q[k-1]),
      .rem_out (rem_nx[k]),
      .dq_out  (dq_nx[k])
    );
  end

  // Only valid bits carry reset and flush semantics; flush wins over stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= N; k++) valid_q[k] <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k <= N; k++) valid_q[k] <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k <= N; k++) valid_q[k] <= valid_q[k-1];
      out_valid <= valid_q[N];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      op_q[0]     <= in_op_e;
      tag_q[0]    <= in_tag;
      pc_q[0]     <= in_pc;
      sign_q_q[0] <= in_signed && (A[XLEN-1] ^ B[XLEN-1]);
      sign_r_q[0] <= in_signed && A[XLEN-1];
      zero_q[0]   <= (B == '0);
      rem_q[0]    <= '0;
      dq_q[0]     <= a_mag;
      dvs_q[0]    <= b_mag;
      for (int k = 1; k <= N; k++) begin
        op_q[k]     <= op_q[k-1];
        tag_q[k]    <= tag_q[k-1];
        pc_q[k]     <= pc_q[k-1];
        sign_q_q[k] <= sign_q_q[k-1];
        sign_r_q[k] <= sign_r_q[k-1];
        zero_q[k]   <= zero_q[k-1];
        rem_q[k]    <= rem_nx[k];
        dq_q[k]     <= dq_nx[k];
      end
      for (int k = 1; k < N; k++) dvs_q[k] <= dvs_q[k-1];
    end
  end

  // With B=0 the array already leaves |A| as remainder, so sign correction restores A exactly
  always_comb begin
    quo_fin = sign_q_q[N] ? -dq_q[N] : dq_q[N];
    if (zero_q[N]) quo_fin = '1;
    rem_fin = sign_r_q[N] ? -rem_q[N] : rem_q[N];
    res_fin = is_rem(op_q[N]) ? rem_fin : quo_fin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result   <= '0;
      div_zero <= 1'b0;
      out_tag  <= '0;
      out_pc   <= '0;
    end else if (!stall) begin
      Result   <= res_fin;
      div_zero <= zero_q[N];
      out_tag  <= tag_q[N];
      out_pc   <= pc_q[N];
    end
  end

endmodule

// File: tb/tb_divider_pipe.sv
// tb/tb_divider_pipe.sv - randomized self-checking bench for divider_pipe against an arithmetic model
module tb_divider_pipe;

  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  in_tag;
  logic [31:0] in_pc;
  logic        out_valid;
  logic [31:0] Result;
  logic        div_zero;
  logic [7:0]  out_tag;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [7:0]  tag;
    logic [31:0] pc;
    int          cyc;
    int          st;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];

  divider_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .A         (A),
    .B         (B),
    .in_tag    (in_tag),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .Result    (Result),
    .div_zero  (div_zero),
    .out_tag   (out_tag),
    .out_pc    (out_pc)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit signed/unsigned arithmetic; SV division truncates toward zero
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return 32'(ua / ub);
      2'b10:   return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] rand_a();
    if ($urandom_range(0, 7) == 0) return 32'h8000_0000;
    return $urandom >> $urandom_range(0, 24);
  endfunction

  function automatic logic [31:0] rand_b();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd0;
    if (r == 1) return 32'hFFFF_FFFF;
    if (r <= 4) return ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20)) : -32'($urandom_range(1, 20));
    return $urandom >> $urandom_range(0, 31);
  endfunction

  // One clock: drive at posedge+1, record consumed outputs at negedge, return at next posedge+1
  task automatic cycle(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] tag, input logic [31:0] pc, input bit st, input bit fl);
    rec_t g;
    in_valid = v;
    in_op    = op;
    A        = a;
    B        = b;
    in_tag   = tag;
    in_pc    = pc;
    stall    = st;
    flush    = fl;
    if (st) stall_cnt++;
    @(negedge clk);
    if (out_valid && !stall && !flush) begin
      g.res = Result;
      g.z   = div_zero;
      g.tag = out_tag;
      g.pc  = out_pc;
      g.cyc = cyc_cnt;
      g.st  = stall_cnt;
      got_q.push_back(g);
    end
    @(posedge clk);
    cyc_cnt++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 32'd0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic [31:0] res, input logic z, input logic [7:0] tag, input logic [31:0] pc);
    rec_t e;
    e.res = res;
    e.z   = z;
    e.tag = tag;
    e.pc  = pc;
    e.cyc = cyc_cnt;
    e.st  = stall_cnt;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_valid, Result, div_zero, out_tag, out_pc} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b r=%h z=%b tag=%h pc=%h, required all zero",
               out_valid, Result, div_zero, out_tag, out_pc);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_idle: got %b required 1", in_ready);
    end
    stall = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_stall: got %b required 0", in_ready);
    end
    stall = 1'b0;
    idle(4);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_out: got %0d results required 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [11] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [31:0] as   [11] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0};
    logic [31:0] bs   [11] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] exps [11] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    logic        expz [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      push_exp(exps[i], expz[i], 8'(8'h15 + i), 32'h400 + 32'(4 * i));
      cycle(1'b1, ops[i], as[i], bs[i], 8'(8'h15 + i), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
    end
    idle(LAT + 6);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL directed_count: got %0d results required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      rec_t g = got_q.pop_front();
      rec_t e = exp_q.pop_front();
      n_checks++;
      if ({g.res, g.z, g.tag, g.pc} !== {e.res, e.z, e.tag, e.pc}) begin
        n_fail++;
        $display("FAIL directed[%0d]: got r=%h z=%b tag=%h pc=%h required r=%h z=%b tag=%h pc=%h",
                 i, g.res, g.z, g.tag, g.pc, e.res, e.z, e.tag, e.pc);
      end
      n_checks++;
      if ((g.cyc - e.cyc) - (g.st - e.st) != LAT) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, (g.cyc - e.cyc) - (g.st - e.st), LAT);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_stall_flush();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic [31:0] pc;
    bit          st;
    int          budget;
    for (int t = 0; t < 21; t++) begin
      st  = (t >= 6 && t <= 8);
      op  = 2'($urandom);
      a   = rand_a();
      b   = rand_b();
      tag = 8'($urandom);
      pc  = $urandom;
      if (!st) push_exp(ref_div(op, a, b), b == 32'd0, tag, pc);
      cycle(1'b1, op, a, b, tag, pc, st, 1'b0);
    end
    budget = 0;
    while (got_q.size() < 5 && budget < 60) begin
      idle(1);
      budget++;
    end
    n_checks++;
    if (got_q.size() < 5) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d results required 5", got_q.size());
    end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      rec_t g = got_q.pop_front();
      rec_t e = exp_q.pop_front();
      n_checks++;
      if ({g.res, g.z, g.tag, g.pc} !== {e.res, e.z, e.tag, e.pc}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got r=%h z=%b tag=%h pc=%h required r=%h z=%b tag=%h pc=%h",
                 i, g.res, g.z, g.tag, g.pc, e.res, e.z, e.tag, e.pc);
      end
      n_checks++;
      if ((g.cyc - e.cyc) - (g.st - e.st) != LAT) begin
        n_fail++;
        $display("FAIL stream_latency[%0d]: got %0d required %0d", i, (g.cyc - e.cyc) - (g.st - e.st), LAT);
      end
    end
    cycle(1'b1, 2'($urandom), rand_a(), rand_b(), 8'($urandom), $urandom, 1'b0, 1'b1);
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_out_valid: got %b required 0", out_valid);
    end
    for (int t = 0; t < 3; t++) begin
      op  = 2'($urandom);
      a   = rand_a();
      b   = rand_b();
      tag = 8'($urandom);
      pc  = $urandom;
      push_exp(ref_div(op, a, b), b == 32'd0, tag, pc);
      cycle(1'b1, op, a, b, tag, pc, 1'b0, 1'b0);
    end
    idle(LAT + 8);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL post_flush_count: got %0d results required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      rec_t g = got_q.pop_front();
      rec_t e = exp_q.pop_front();
      n_checks++;
      if ({g.res, g.z, g.tag, g.pc} !== {e.res, e.z, e.tag, e.pc}) begin
        n_fail++;
        $display("FAIL post_flush[%0d]: got r=%h z=%b tag=%h pc=%h required r=%h z=%b tag=%h pc=%h",
                 i, g.res, g.z, g.tag, g.pc, e.res, e.z, e.tag, e.pc);
      end
      n_checks++;
      if (g.cyc - e.cyc != LAT) begin
        n_fail++;
        $display("FAIL post_flush_latency[%0d]: got %0d required %0d", i, g.cyc - e.cyc, LAT);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_in_flight();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int t = 0; t < 20; t++) begin
      op = 2'($urandom);
      a  = rand_a();
      b  = rand_b();
      push_exp(ref_div(op, a, b), b == 32'd0, 8'(t), 32'(t * 4));
      cycle(1'b1, op, a, b, 8'(t), 32'(t * 4), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b required 1", out_valid);
    end
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %0d results required 2", got_q.size());
    end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      rec_t g = got_q.pop_front();
      rec_t e = exp_q.pop_front();
      n_checks++;
      if ({g.res, g.z, g.tag, g.pc} !== {e.res, e.z, e.tag, e.pc}) begin
        n_fail++;
        $display("FAIL pre_reset[%0d]: got r=%h z=%b tag=%h pc=%h required r=%h z=%b tag=%h pc=%h",
                 i, g.res, g.z, g.tag, g.pc, e.res, e.z, e.tag, e.pc);
      end
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, Result, div_zero, out_tag, out_pc} !== 74'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%h z=%b tag=%h pc=%h, required all zero",
               out_valid, Result, div_zero, out_tag, out_pc);
    end
    @(posedge clk);
    cyc_cnt++;
    #1;
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    idle(LAT + 6);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_leak: got %0d results required 0", got_q.size());
    end
    got_q.delete();
    push_exp(32'd5, 1'b0, 8'hA5, 32'h1234);
    cycle(1'b1, 2'b01, 32'd47, 32'd9, 8'hA5, 32'h1234, 1'b0, 1'b0);
    idle(LAT + 4);
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d results required 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      rec_t g = got_q.pop_front();
      rec_t e = exp_q.pop_front();
      n_checks++;
      if ({g.res, g.z, g.tag, g.pc, g.cyc - e.cyc} !== {e.res, e.z, e.tag, e.pc, LAT}) begin
        n_fail++;
        $display("FAIL post_reset_op: got r=%h z=%b tag=%h pc=%h lat=%0d required r=%h z=%b tag=%h pc=%h lat=%0d",
                 g.res, g.z, g.tag, g.pc, g.cyc - e.cyc, e.res, e.z, e.tag, e.pc, LAT);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_op    = 2'b00;
    A        = 32'd0;
    B        = 32'd0;
    in_tag   = 8'd0;
    in_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_stall_flush();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
